note_sequencer: RTL
===================

NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 SHALL have parameter POS_BITS, default 8, width of score position.
REQ-002 SHALL have parameter ARRAY_SIZE, default 256, number of score entries; index ARRAY_SIZE-1 is the last entry.
REQ-003 SHALL have parameter NOTE_BITS, default 6, note code width; code 0 means rest.
REQ-004 SHALL have parameter DUR_BITS, default 4, note duration width in beats.
REQ-005 SHALL have port clk input 1, sole clock, all state changes on its rising edge.
REQ-006 SHALL have port rst input 1, reset, synchronous and active-high.
REQ-007 SHALL have port play input 1, level; 1 runs, 0 pauses.
REQ-008 SHALL have port beat input 1, single-cycle tempo tick.
REQ-009 SHALL have port pos input POS_BITS, current index from the position counter, also the score ROM address.
REQ-010 SHALL have port rom_data input NOTE_BITS+DUR_BITS, {note, dur} for address pos, with 1-cycle registered latency.
REQ-011 SHALL have port advance output 1, one-cycle pulse driving the position counter enable.
REQ-012 SHALL have port note output NOTE_BITS, current note code.
REQ-013 SHALL have port note_valid output 1, high while a non-rest note sounds.
REQ-014 SHALL have port done output 1, score finished (non-loop build only).

Function
REQ-015 SHALL implement states IDLE, FETCH, LOAD, PLAY, ADVANCE, DONE.
REQ-016 IDLE->FETCH SHALL occur when play=1; IDLE SHALL hold otherwise.
REQ-017 FETCH SHALL last one cycle, letting the ROM register pos; then LOAD.
REQ-018 LOAD SHALL capture rom_data into note/dur registers, clear the beat count, then enter PLAY.
REQ-019 PLAY SHALL increment the beat count on beat=1 && play=1; beat SHALL be ignored in every other state and while play=0.
REQ-020 A dur of 0 SHALL be treated as 1 beat.
REQ-021 When an accepted beat makes the count equal the effective dur, PLAY SHALL go to ADVANCE on that edge.
REQ-022 ADVANCE SHALL assert advance for exactly one cycle, then FETCH; first note_valid of the next entry SHALL follow 3 cycles after ADVANCE.
REQ-023 note_valid SHALL be high only in PLAY with play=1 and note!=0; note SHALL hold the loaded code through PLAY and ADVANCE.
REQ-024 play=0 in any state other than IDLE or DONE SHALL freeze state and beat count; play=1 SHALL resume with no beat lost or duplicated.
REQ-025 advance SHALL never be asserted in two consecutive cycles.

Reset
REQ-026 rst=1 SHALL force IDLE with advance=0, note=0, note_valid=0, done=0, beat count=0 on the next edge, from any state including mid-note; rst SHALL take priority over all other inputs.
REQ-027 The position counter SHALL share rst, so pos=0 on the first FETCH after reset.

Configuration
REQ-028 With macro NOTE_SEQUENCER_LOOP_EN defined, ADVANCE on pos==ARRAY_SIZE-1 SHALL pulse advance (counter wraps to 0) and continue; done SHALL be constant 0.
REQ-029 Without NOTE_SEQUENCER_LOOP_EN, completing the entry at pos==ARRAY_SIZE-1 SHALL enter DONE without pulsing advance; DONE SHALL hold done=1, note_valid=0 until rst.

Structure
REQ-030 State encoding enum and the {note, dur} field slice constants SHALL live in shared package score_pkg.
REQ-031 Beat counting SHALL be a sub-module beat_counter (clear, en, terminal-count compare), built on dffre.

Verification (ARRAY_SIZE=4, ROM = {(5,2),(0,1),(7,0),(3,3)})
REQ-032 rst, play=1, beat every 10 cycles -> note 5 valid for 2 beats, rest for 1 beat with note_valid=0, note 7 for 1 beat, note 3 for 3 beats; advance pulses exactly 3 times.
REQ-033 Non-loop build, same run -> after 3rd beat of note 3, done=1, no 4th advance, pos stays 3.
REQ-034 Loop build, same run -> 4th advance pulse, pos wraps to 0, note 5 valid again 3 cycles later.
REQ-035 play=0 for 25 cycles mid-note 3 with beats arriving -> state and count frozen; after resume exactly the remaining beats elapse.
REQ-036 rst asserted during ADVANCE -> next cycle advance=0, IDLE, all outputs 0; restart plays from note 5.
REQ-037 beat asserted during FETCH/LOAD/ADVANCE -> ignored, durations unchanged.

Source files
------------

// File: rtl/score_pkg.sv
// Shared sequencer state encoding and score word field layout.
package score_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_LOAD    = 3'd2,
    ST_PLAY    = 3'd3,
    ST_ADVANCE = 3'd4,
    ST_DONE    = 3'd5
  } seq_state_e;

  // Score word is {note, dur}: dur sits at bit 0, note directly above it.
  localparam int unsigned DUR_LSB   = 0;
  localparam int unsigned NOTE_REST = 0;

endpackage

// File: rtl/beat_counter.sv
// Beat counter with clear, count enable and a terminal-count look-ahead compare.
module beat_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] limit,
  output logic             tc_next
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH:0]   next_ext;
  logic [WIDTH:0]   limit_eff;
  logic             load_en;

  // tc_next is high when one more accepted beat completes the note; a zero limit counts as one beat.
  always_comb begin
    limit_eff = (limit == '0) ? (WIDTH+1)'(1) : {1'b0, limit};
    next_ext  = {1'b0, count_q} + (WIDTH+1)'(1);
    tc_next   = (next_ext == limit_eff);
    load_en   = clear || en;
    count_d   = clear ? '0 : next_ext[WIDTH-1:0];
  end

  dffre #(.WIDTH(WIDTH)) u_count (
    .clk (clk),
    .rst (rst),
    .en  (load_en),
    .d   (count_d),
    .q   (count_q)
  );

endmodule

// File: rtl/dffre.sv
// Register with synchronous active-high reset and load enable.
module dffre #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// Steps through a {note, dur} score ROM, holding each note for dur tempo beats.
// Define NOTE_SEQUENCER_LOOP_EN to wrap after the last entry instead of stopping in DONE.
module note_sequencer
  import score_pkg::*;
#(
  parameter int unsigned POS_BITS   = 8,
  parameter int unsigned ARRAY_SIZE = 256,
  parameter int unsigned NOTE_BITS  = 6,
  parameter int unsigned DUR_BITS   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          play,
  input  logic                          beat,
  input  logic [POS_BITS-1:0]           pos,
  input  logic [NOTE_BITS+DUR_BITS-1:0] rom_data,
  output logic                          advance,
  output logic [NOTE_BITS-1:0]          note,
  output logic                          note_valid,
  output logic                          done
);

  localparam int unsigned NOTE_LSB = DUR_LSB + DUR_BITS;

  seq_state_e           state_q, state_d;
  logic [NOTE_BITS-1:0] note_q, note_d;
  logic [DUR_BITS-1:0]  dur_q, dur_d;
  logic                 cnt_clear;
  logic                 cnt_en;
  logic                 cnt_tc;
  logic                 at_last;
  logic                 stop_at_end;

  assign at_last = (pos == POS_BITS'(ARRAY_SIZE - 1));

`ifdef NOTE_SEQUENCER_LOOP_EN
  logic unused_at_last;
  assign unused_at_last = at_last;
  assign stop_at_end    = 1'b0;
  assign done           = 1'b0;
`else
  assign stop_at_end = at_last;
  assign done        = (state_q == ST_DONE);
`endif

  beat_counter #(.WIDTH(DUR_BITS)) u_beat_counter (
    .clk     (clk),
    .rst     (rst),
    .clear   (cnt_clear),
    .en      (cnt_en),
    .limit   (dur_q),
    .tc_next (cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      note_q  <= '0;
      dur_q   <= '0;
    end else begin
      state_q <= state_d;
      note_q  <= note_d;
      dur_q   <= dur_d;
    end
  end

  // Outside IDLE and DONE a low play level freezes the state, so every transition is gated by play.
  always_comb begin
    state_d   = state_q;
    note_d    = note_q;
    dur_d     = dur_q;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (play) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (play) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (play) begin
          note_d    = rom_data[NOTE_LSB +: NOTE_BITS];
          dur_d     = rom_data[DUR_LSB +: DUR_BITS];
          cnt_clear = 1'b1;
          state_d   = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (play && beat) begin
          cnt_en = 1'b1;
          if (cnt_tc) state_d = stop_at_end ? ST_DONE : ST_ADVANCE;
        end
      end
      ST_ADVANCE: begin
        if (play) state_d = ST_FETCH;
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // advance is qualified by play so a paused ADVANCE state cannot bump the position counter twice.
  assign advance    = (state_q == ST_ADVANCE) && play;
  assign note       = note_q;
  assign note_valid = (state_q == ST_PLAY) && play && (note_q != NOTE_BITS'(NOTE_REST));

endmodule
